// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: password-gated entry, pass/timeout close, lockout
// after repeated wrong passwords, and an occupancy counter shared with the exit lane.
module parking_gate_ctrl #(
  parameter int PSWD_W       = 8,
  parameter int PSWD_VAL     = 253,
  parameter int CAPACITY     = 16,
  parameter int MAX_TRIES    = 3,
  parameter int OPEN_TIMEOUT = 64,
  parameter int LOCK_CYCLES  = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          car,
  input  logic                          bk_sens,
  input  logic [PSWD_W-1:0]             pswd,
  input  logic                          pswd_vld,
  input  logic                          car_exit,
  output logic                          gate,
  output logic [$clog2(CAPACITY+1)-1:0] count,
  output logic                          full,
  output logic                          lock,
  output logic                          err,
  output logic [1:0]                    state_dbg
);

  localparam int CW = $clog2(CAPACITY + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int OW = $clog2(OPEN_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  localparam logic [PSWD_W-1:0] PSWD_KEY  = PSWD_W'(PSWD_VAL);
  localparam logic [CW-1:0]     CAP       = CW'(CAPACITY);
  localparam logic [TW-1:0]     TRIES_LIM = TW'(MAX_TRIES);
  localparam logic [OW-1:0]     OPEN_LAST = OW'(OPEN_TIMEOUT - 1);
  localparam logic [LW-1:0]     LOCK_LAST = LW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PSWD = 2'd1,
    OPEN      = 2'd2,
    LOCKED    = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tries, tries_nxt;
  logic [OW-1:0] open_tmr, open_tmr_nxt;
  logic [LW-1:0] lock_tmr, lock_tmr_nxt;
  logic [CW-1:0] count_nxt;
  logic          err_nxt;
  logic          pass;
  logic          dec;

  // pswd is only looked at in the cycle pswd_vld is high; there is no
  // back-pressure, a strobe outside WAIT_PSWD is simply dropped.
  always_comb begin
    state_nxt    = state;
    tries_nxt    = tries;
    open_tmr_nxt = open_tmr;
    lock_tmr_nxt = lock_tmr;
    err_nxt      = 1'b0;
    pass         = 1'b0;
    case (state)
      IDLE: begin
        if (car && !full) state_nxt = WAIT_PSWD;
      end
      WAIT_PSWD: begin
        if (pswd_vld) begin
          if (pswd == PSWD_KEY) begin
            state_nxt    = OPEN;
            tries_nxt    = '0;
            open_tmr_nxt = '0;
          end else begin
            err_nxt   = 1'b1;
            tries_nxt = tries + 1'b1;
            if (tries_nxt == TRIES_LIM) begin
              state_nxt    = LOCKED;
              lock_tmr_nxt = '0;
            end
          end
        end else if (!car) begin
          state_nxt = IDLE;
          tries_nxt = '0;
        end
      end
      OPEN: begin
        if (bk_sens) begin
          pass      = 1'b1;
          state_nxt = IDLE;
        end else if (open_tmr == OPEN_LAST) begin
          state_nxt = IDLE;
        end else begin
          open_tmr_nxt = open_tmr + 1'b1;
        end
      end
      LOCKED: begin
        if (lock_tmr == LOCK_LAST) begin
          state_nxt = IDLE;
          tries_nxt = '0;
        end else begin
          lock_tmr_nxt = lock_tmr + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Entry and exit in the same cycle cancel; both directions saturate.
  assign dec = car_exit && (count != '0);

  always_comb begin
    count_nxt = count;
    if (pass && !dec) begin
      if (count != CAP) count_nxt = count + 1'b1;
    end else if (dec && !pass) begin
      count_nxt = count - 1'b1;
    end
  end

  assign full      = (count == CAP);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tries    <= '0;
      open_tmr <= '0;
      lock_tmr <= '0;
      count    <= '0;
      gate     <= 1'b0;
      lock     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      tries    <= tries_nxt;
      open_tmr <= open_tmr_nxt;
      lock_tmr <= lock_tmr_nxt;
      count    <= count_nxt;
      gate     <= (state_nxt == OPEN);
      lock     <= (state_nxt == LOCKED);
      err      <= err_nxt;
    end
  end

  a_gate_lock_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(gate && lock));
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CAP);
  a_gate_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
    gate == (state == OPEN));
  a_lock_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
    lock == (state == LOCKED));

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: a cycle model built from counts of
// remaining open/lock cycles is compared on every falling edge, plus literal checks.
module tb_parking_gate_ctrl;

  localparam int         CAP    = 16;
  localparam int         OPEN_T = 64;
  localparam int         LOCK_T = 256;
  localparam int         TRIES  = 3;
  localparam logic [7:0] KEY    = 8'd253;

  logic       clk;
  logic       rst_n;
  logic       car;
  logic       bk_sens;
  logic [7:0] pswd;
  logic       pswd_vld;
  logic       car_exit;
  logic       gate;
  logic [4:0] count;
  logic       full;
  logic       lock;
  logic       err;
  logic [1:0] state_dbg;

  int total;
  int bad;
  int gate_cyc;
  int lock_cyc;
  int err_cyc;
  bit chk_en;

  int m_cars;
  int m_open_left;
  int m_lock_left;
  int m_tries;
  bit m_waiting;
  bit m_err;
  bit m_inc;
  bit m_dec;

  parking_gate_ctrl #(
    .PSWD_W(8), .PSWD_VAL(253), .CAPACITY(CAP), .MAX_TRIES(TRIES),
    .OPEN_TIMEOUT(OPEN_T), .LOCK_CYCLES(LOCK_T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .car(car), .bk_sens(bk_sens), .pswd(pswd),
    .pswd_vld(pswd_vld), .car_exit(car_exit), .gate(gate), .count(count),
    .full(full), .lock(lock), .err(err), .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: gate is open while open cycles remain, locked while lock cycles remain.
  task automatic model_loop();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cars = 0; m_open_left = 0; m_lock_left = 0;
        m_tries = 0; m_waiting = 0; m_err = 0;
      end else begin
        m_inc = 0;
        m_err = 0;
        m_dec = car_exit && (m_cars > 0);
        if (m_lock_left > 0) begin
          m_lock_left--;
          if (m_lock_left == 0) m_tries = 0;
        end else if (m_open_left > 0) begin
          if (bk_sens) begin
            m_inc = 1;
            m_open_left = 0;
          end else begin
            m_open_left--;
          end
        end else if (m_waiting) begin
          if (pswd_vld) begin
            if (pswd == KEY) begin
              m_waiting = 0; m_tries = 0; m_open_left = OPEN_T;
            end else begin
              m_err = 1;
              m_tries++;
              if (m_tries == TRIES) begin
                m_waiting = 0; m_lock_left = LOCK_T;
              end
            end
          end else if (!car) begin
            m_waiting = 0; m_tries = 0;
          end
        end else if (car && m_cars < CAP) begin
          m_waiting = 1;
        end
        if (m_inc && !m_dec) m_cars = (m_cars < CAP) ? m_cars + 1 : CAP;
        else if (m_dec && !m_inc) m_cars--;
      end
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc_gate", int'(gate), int'(m_open_left > 0));
        check("cyc_lock", int'(lock), int'(m_lock_left > 0));
        check("cyc_err", int'(err), int'(m_err));
        check("cyc_count", int'(count), m_cars);
        check("cyc_full", int'(full), int'(m_cars == CAP));
      end
      if (gate === 1'b1) gate_cyc++;
      if (lock === 1'b1) lock_cyc++;
      if (err === 1'b1) err_cyc++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] v);
    pswd = v;
    pswd_vld = 1'b1;
    tick(1);
    pswd_vld = 1'b0;
  endtask

  task automatic enter_car();
    car = 1'b1;
    tick(1);
    strobe(KEY);
    car = 1'b0;
    bk_sens = 1'b1;
    tick(1);
    bk_sens = 1'b0;
  endtask

  task automatic exit_car();
    car_exit = 1'b1;
    tick(1);
    car_exit = 1'b0;
  endtask

  initial begin
    int e0, l0, g0;
    rst_n = 1'b0; car = 1'b0; bk_sens = 1'b0; pswd = '0;
    pswd_vld = 1'b0; car_exit = 1'b0;
    total = 0; bad = 0; gate_cyc = 0; lock_cyc = 0; err_cyc = 0; chk_en = 0;
    fork
      model_loop();
      compare_loop();
    join_none
    tick(3);
    chk_en = 1;
    check("reset_gate", int'(gate), 0);
    check("reset_count", int'(count), 0);
    check("reset_lock", int'(lock), 0);
    check("reset_err", int'(err), 0);
    rst_n = 1'b1;

    // Correct password then pass
    car = 1'b1;
    tick(2);
    check("s1_gate_before", int'(gate), 0);
    strobe(KEY);
    check("s1_gate_open", int'(gate), 1);
    car = 1'b0;
    bk_sens = 1'b1;
    tick(1);
    bk_sens = 1'b0;
    check("s1_gate_closed", int'(gate), 0);
    check("s1_count", int'(count), 1);

    // Three wrong passwords then lockout
    e0 = err_cyc; l0 = lock_cyc;
    car = 1'b1;
    tick(1);
    strobe(8'd12);
    check("s2_err_first", int'(err), 1);
    check("s2_lock_early", int'(lock), 0);
    strobe(8'd13);
    strobe(8'd14);
    check("s2_lock_on", int'(lock), 1);
    repeat (3) begin
      strobe(KEY);
      tick(2);
    end
    check("s2_gate_in_lock", int'(gate), 0);
    car = 1'b0;
    for (int i = 0; i < 400 && lock; i++) tick(1);
    check("s2_lock_fall", int'(lock), 0);
    check("s2_err_pulses", err_cyc - e0, 3);
    check("s2_lock_len", lock_cyc - l0, 256);

    // Timeout with no pass
    g0 = gate_cyc;
    car = 1'b1;
    tick(1);
    strobe(KEY);
    car = 1'b0;
    for (int i = 0; i < 100 && gate; i++) tick(1);
    check("s3_gate_closed", int'(gate), 0);
    check("s3_gate_len", gate_cyc - g0, 64);
    check("s3_count", int'(count), 1);

    // Fill the lot, blocked entry, exit, re-entry
    for (int i = 0; i < 15; i++) enter_car();
    check("s4_count_full", int'(count), 16);
    check("s4_full", int'(full), 1);
    car = 1'b1;
    tick(4);
    strobe(KEY);
    tick(1);
    check("s4_blocked_gate", int'(gate), 0);
    check("s4_blocked_err", int'(err), 0);
    exit_car();
    check("s4_count_exit", int'(count), 15);
    check("s4_full_drop", int'(full), 0);
    tick(1);
    strobe(KEY);
    check("s4_reentry_gate", int'(gate), 1);
    car = 1'b0;
    bk_sens = 1'b1;
    tick(1);
    bk_sens = 1'b0;
    check("s4_count_refill", int'(count), 16);
    for (int i = 0; i < 11; i++) exit_car();
    check("s4_count_drain", int'(count), 5);

    // Simultaneous entry and exit; exit at empty
    car = 1'b1;
    tick(1);
    strobe(KEY);
    car = 1'b0;
    bk_sens = 1'b1;
    car_exit = 1'b1;
    tick(1);
    bk_sens = 1'b0;
    car_exit = 1'b0;
    check("s5_count_same", int'(count), 5);
    for (int i = 0; i < 5; i++) exit_car();
    check("s5_count_zero", int'(count), 0);
    exit_car();
    check("s5_count_floor", int'(count), 0);

    // Asynchronous reset mid-OPEN
    enter_car();
    car = 1'b1;
    tick(1);
    strobe(KEY);
    car = 1'b0;
    check("s6_gate_open", int'(gate), 1);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_gate", int'(gate), 0);
    check("s6_rst_count", int'(count), 0);
    check("s6_rst_lock", int'(lock), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Asynchronous reset mid-LOCKED
    car = 1'b1;
    tick(1);
    strobe(8'd1);
    strobe(8'd2);
    strobe(8'd3);
    check("s7_lock_on", int'(lock), 1);
    car = 1'b0;
    tick(10);
    #2 rst_n = 1'b0;
    #1;
    check("s7_rst_lock", int'(lock), 0);
    check("s7_rst_gate", int'(gate), 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("s7_lock_stays_off", int'(lock), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
